// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame generator: FSM states, LFSR taps, frame sizing.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic int frame_width(input int hdr_w, input int data_w, input bit par);
      return hdr_w + data_w + (par ? 1 : 0);
   endfunction

endpackage

// File: rtl/serial_frame_gen_lfsr16.sv
// 16-bit Galois LFSR (shift right, feedback from bit 0); advances one step per cycle with step=1.
// Also instantiated by the deserializer bench as a reference sequence generator.
module lfsr16
   import serial_frame_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   always_comb begin
      q_d = q_q;
      if (step) begin
         q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= seed;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/serial_frame_gen.sv
// Serial frame source: N_FRAMES frames of {HDR_PAT, data[, parity]} on txd, CLK_DIV cycles per bit.
// Define SERIAL_FRAME_GEN_PARITY_EN to append an even parity bit after the data.
module serial_frame_gen
   import serial_frame_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter int               HDR_W     = 4,
   parameter logic [HDR_W-1:0] HDR_PAT   = 4'b1010,
   parameter int               CLK_DIV   = 4,
   parameter int               N_FRAMES  = 16,
   parameter logic [15:0]      LFSR_SEED = 16'hACE1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              lfsr_mode,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              txd,
   output logic              bit_strobe,
   output logic              frame_start,
   output logic              busy,
   output logic              done,
   output logic [15:0]       frame_cnt
);

`ifdef SERIAL_FRAME_GEN_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int FW    = frame_width(HDR_W, DATA_W, PAR_EN);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(FW);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);
   localparam logic [15:0]      N_LAST   = 16'(N_FRAMES);

   function automatic logic [FW-1:0] pack_frame(input logic [DATA_W-1:0] d);
`ifdef SERIAL_FRAME_GEN_PARITY_EN
      return {HDR_PAT, d, ^d};
`else
      return {HDR_PAT, d};
`endif
   endfunction

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [FW-1:0]    shreg_q, shreg_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [15:0]      lfsr_q;
   logic             lfsr_step;
   logic [DATA_W-1:0] fetch_dat;
   logic             unused_lfsr;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .step (lfsr_step),
      .seed (LFSR_SEED),
      .q    (lfsr_q)
   );

   // Only the low DATA_W bits feed the payload; the rest is LFSR state.
   assign unused_lfsr = ^lfsr_q;
   assign fetch_dat   = lfsr_mode ? lfsr_q[DATA_W-1:0] : data_in;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      frame_cnt_d = frame_cnt_q;
      lfsr_step   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = FETCH;
               frame_cnt_d = 16'd0;
            end
         end
         FETCH: begin
            if (lfsr_mode || data_valid) begin
               lfsr_step = lfsr_mode;
               shreg_d   = pack_frame(fetch_dat);
               div_d     = '0;
               bit_d     = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               shreg_d = shreg_q << 1;
               if (bit_q == BIT_LAST) begin
                  bit_d       = '0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  // N_FRAMES == 0 runs forever; frame_cnt simply wraps.
                  if ((N_FRAMES != 0) && (frame_cnt_q + 16'd1 == N_LAST)) state_d = DONE;
                  else                                                     state_d = FETCH;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         frame_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign txd         = (state_q == SHIFT) && shreg_q[FW-1];
   assign bit_strobe  = (state_q == SHIFT) && (div_q == DIV_LAST);
   assign frame_start = (state_q == SHIFT) && (div_q == '0) && (bit_q == '0);
   assign data_ready  = (state_q == FETCH) && !lfsr_mode;
   assign busy        = (state_q == FETCH) || (state_q == SHIFT);
   assign done        = (state_q == DONE);
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_gen.sv
// Bench for serial_frame_gen (default parameters); build with SERIAL_FRAME_GEN_PARITY_EN for parity frames.
module tb_serial_frame_gen;

   localparam int CD = 4;
`ifdef SERIAL_FRAME_GEN_PARITY_EN
   localparam int          FW    = 13;
   localparam int          RUN   = 848;
   localparam logic [12:0] L_E1  = 13'h15C2;
   localparam logic [12:0] L_70  = 13'h14E1;
   localparam logic [12:0] L_38  = 13'h1471;
   localparam logic [12:0] L_A5  = 13'h154A;
   localparam logic [12:0] L_3C  = 13'h1478;
`else
   localparam int          FW    = 12;
   localparam int          RUN   = 784;
   localparam logic [11:0] L_E1  = 12'hAE1;
   localparam logic [11:0] L_70  = 12'hA70;
   localparam logic [11:0] L_38  = 12'hA38;
   localparam logic [11:0] L_A5  = 12'hAA5;
   localparam logic [11:0] L_3C  = 12'hA3C;
`endif
   localparam int FL = FW * CD;

   logic        clk = 1'b0;
   logic        rst, start, lfsr_mode, data_valid;
   logic [7:0]  data_in;
   logic        data_ready, txd, bit_strobe, frame_start, busy, done;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   serial_frame_gen dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .lfsr_mode   (lfsr_mode),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .txd         (txd),
      .bit_strobe  (bit_strobe),
      .frame_start (frame_start),
      .busy        (busy),
      .done        (done),
      .frame_cnt   (frame_cnt)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] frame_of(input logic [7:0] d);
`ifdef SERIAL_FRAME_GEN_PARITY_EN
      return {4'b1010, d, ^d};
`else
      return {4'b1010, d};
`endif
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Reference model: expected payload sequence and per-cycle shape of each frame.
   logic [15:0]   m_lfsr = 16'hACE1;
   logic [7:0]    exp_q[$];
   logic [FW-1:0] captured[$];
   logic [FW-1:0] cur_exp = '0;
   logic [FW-1:0] cap_cur = '0;
   bit            in_frame = 1'b0;
   int            cyc = 0;
   int            cap_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         m_lfsr   = 16'hACE1;
         cap_cnt  = 0;
         exp_q.delete();
      end else begin
         if (!in_frame && frame_start) begin
            in_frame = 1'b1;
            cyc      = 0;
            if (lfsr_mode) begin
               cur_exp = frame_of(m_lfsr[7:0]);
               m_lfsr  = lfsr_next(m_lfsr);
            end else if (exp_q.size() > 0) begin
               cur_exp = frame_of(exp_q.pop_front());
            end else begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame: frame_start with no queued payload (t=%0t)", $time);
               cur_exp = '0;
            end
         end
         if (in_frame) begin
            check("txd", txd, cur_exp[FW-1-cyc/CD]);
            check("bit_strobe", bit_strobe, (cyc % CD) == CD - 1);
            check("frame_start", frame_start, cyc == 0);
            check("busy_in_frame", busy, 1'b1);
            cyc++;
            if (cyc == FL) in_frame = 1'b0;
         end else begin
            check("txd_idle", txd, 1'b0);
            check("strobe_idle", bit_strobe, 1'b0);
         end
         if (frame_start) begin
            cap_cnt = 0;
            cap_cur = '0;
         end
         if (bit_strobe) begin
            cap_cur = {cap_cur[FW-2:0], txd};
            cap_cnt++;
            if (cap_cnt == FW) captured.push_back(cap_cur);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(inout int n);
      while (!done && n < 4000) begin
         tick();
         n++;
      end
   endtask

   task automatic send_stream(input logic [7:0] d);
      int n = 0;
      while (!data_ready && n < 200) begin
         tick();
         n++;
      end
      check("stream_ready_timeout", n < 200, 1'b1);
      data_in    = d;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   initial begin
      int n;
      int cnt;
      int fs;
      rst        = 1'b1;
      start      = 1'b0;
      lfsr_mode  = 1'b0;
      data_in    = 8'h00;
      data_valid = 1'b0;
      repeat (3) tick();
      check("rst_txd", txd, 1'b0);
      check("rst_ready", data_ready, 1'b0);
      check("rst_strobe", bit_strobe, 1'b0);
      check("rst_fstart", frame_start, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cnt", frame_cnt, 16'd0);
      rst = 1'b0;
      tick();

      // Full LFSR run.
      lfsr_mode = 1'b1;
      captured.delete();
      do_start();
      check("t1_fetch_busy", busy, 1'b1);
      check("t1_fetch_nostart", frame_start, 1'b0);
      tick();
      n = 1;
      check("t1_first_bit_latency", frame_start, 1'b1);
      wait_done(n);
      check("t1_run_cycles", n, RUN);
      check("t1_frame_cnt", frame_cnt, 16'd16);
      check("t1_frames", captured.size(), 16);
      check("t1_frame0", captured[0], L_E1);
      check("t1_frame1", captured[1], L_70);
      check("t1_frame2", captured[2], L_38);
      check("t1_busy_done", busy, 1'b0);
      pulse_rst();

      // Stream mode with data held valid.
      lfsr_mode  = 1'b0;
      data_in    = 8'hA5;
      data_valid = 1'b1;
      repeat (16) exp_q.push_back(8'hA5);
      captured.delete();
      do_start();
      cnt = 0;
      for (int i = 0; i < 2 * (FL + 1); i++) begin
         if (data_ready) cnt++;
         tick();
      end
      check("t2_ready_cycles", cnt, 2);
      check("t2_frames", captured.size(), 2);
      check("t2_frame0", captured[0], L_A5);
      data_valid = 1'b0;
      pulse_rst();

      // Stall in FETCH, then one frame of 3C.
      lfsr_mode = 1'b0;
      exp_q.push_back(8'h3C);
      captured.delete();
      do_start();
      for (int i = 0; i < 20; i++) begin
         check("t3_stall_busy", busy, 1'b1);
         check("t3_stall_ready", data_ready, 1'b1);
         tick();
      end
      send_stream(8'h3C);
      repeat (FL + 2) tick();
      check("t3_frame", captured[0], L_3C);
      check("t3_cnt", frame_cnt, 16'd1);
      pulse_rst();

      // Reset in the middle of bit 6 of frame 3.
      lfsr_mode = 1'b1;
      do_start();
      fs = 0;
      n  = 0;
      while (fs < 3 && n < 1000) begin
         tick();
         n++;
         if (frame_start) fs++;
      end
      check("t4_third_frame_seen", fs, 3);
      repeat (6 * CD + 1) tick();
      check("t4_cnt_before", frame_cnt, 16'd2);
      pulse_rst();
      check("t4_txd", txd, 1'b0);
      check("t4_strobe", bit_strobe, 1'b0);
      check("t4_fstart", frame_start, 1'b0);
      check("t4_busy", busy, 1'b0);
      check("t4_done", done, 1'b0);
      check("t4_cnt", frame_cnt, 16'd0);

      // Restart from the seed; start pulsed mid-frame must be ignored.
      captured.delete();
      do_start();
      n = 0;
      repeat (5 * (FL + 1) + 10) begin
         tick();
         n++;
      end
      check("t5_cnt_mid", frame_cnt, 16'd5);
      do_start();
      n++;
      wait_done(n);
      check("t5_run_cycles", n, RUN);
      check("t5_cnt", frame_cnt, 16'd16);
      check("t5_frame0_seed", captured[0], L_E1);

      // Start in DONE launches a new run.
      captured.delete();
      do_start();
      check("t5_restart_busy", busy, 1'b1);
      check("t5_restart_done", done, 1'b0);
      check("t5_restart_cnt", frame_cnt, 16'd0);
      n = 0;
      wait_done(n);
      check("t5_rerun_cycles", n, RUN);
      check("t5_rerun_frames", captured.size(), 16);

`ifdef SERIAL_FRAME_GEN_PARITY_EN
      pulse_rst();
      lfsr_mode = 1'b0;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'hA4);
      captured.delete();
      do_start();
      send_stream(8'hA5);
      send_stream(8'hA4);
      repeat (FL + 4) tick();
      check("t6_par_a5", captured[0], 13'h154A);
      check("t6_par_a4", captured[1], 13'h1549);
      check("t6_cnt", frame_cnt, 16'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
